htf_array_inc: RTL and testbench

//  Register array of DEPTH counters, each WIDTH bits, indexed RANGE_BASE..RANGE_BASE+DEPTH-1.

---
 rtl/htf_array_inc.sv | 83 ++++++++
 tb/tb_htf_array_inc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/htf_array_inc.sv
// ---------------------------------------------------------------------------
// htf_array_inc
//   Array of DEPTH counters, WIDTH bits each, indexed RANGE_BASE upward.
//   Each entry can be preloaded, or bumped by up to NUM_INC_PORTS increment
//   ports in the same cycle. It holds the per-bit-length SLT write pointers
//   of the XP10 Huffman table flow: base pointers are preloaded, then one
//   entry is bumped for each symbol written.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous reset, active HIGH despite the name
//   preload_en   : per-entry preload enable
//   preload_data : value loaded into every enabled entry
//   inc_onehot   : per-port entry select; each set bit adds one
//   array        : current entry values, straight from the registers
// ---------------------------------------------------------------------------
module htf_array_inc #(
  parameter int DEPTH         = 27,
  parameter int RANGE_BASE    = 1,
  parameter int WIDTH         = 10,
  parameter int NUM_INC_PORTS = 2
) (
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic [RANGE_BASE+DEPTH-1:RANGE_BASE]                        preload_en,
  input  logic [WIDTH-1:0]                                            preload_data,
  input  logic [NUM_INC_PORTS-1:0][RANGE_BASE+DEPTH-1:RANGE_BASE]     inc_onehot,
  output logic [RANGE_BASE+DEPTH-1:RANGE_BASE][WIDTH-1:0]             array
);

  localparam int HI = RANGE_BASE + DEPTH - 1;
  localparam int CW = $clog2(NUM_INC_PORTS + 1);

  logic [HI:RANGE_BASE][WIDTH-1:0] entry_r;
  logic [HI:RANGE_BASE][WIDTH-1:0] entry_nxt_s;
  logic [HI:RANGE_BASE][CW-1:0]    inc_cnt_s;

  // Number of ports selecting entry e; wide enough for all ports at once.
  function automatic logic [CW-1:0] count_hits(
    input logic [NUM_INC_PORTS-1:0][HI:RANGE_BASE] sel,
    input int                                     e
  );
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int p = 0; p < NUM_INC_PORTS; p++) begin
      n = n + CW'(sel[p][e]);
    end
    return n;
  endfunction

  // Per-entry increment count across all ports.
  always_comb begin
    inc_cnt_s = '0;
    for (int e = RANGE_BASE; e <= HI; e++) begin
      inc_cnt_s[e] = count_hits(inc_onehot, e);
    end
  end

  // Next entry value: preload wins and drops same-cycle increments;
  // otherwise add the hit count, wrapping modulo 2^WIDTH.
  always_comb begin
    entry_nxt_s = entry_r;
    for (int e = RANGE_BASE; e <= HI; e++) begin
      if (preload_en[e]) begin
        entry_nxt_s[e] = preload_data;
      end else begin
        entry_nxt_s[e] = entry_r[e] + WIDTH'(inc_cnt_s[e]);
      end
    end
  end

  // Entry registers; reset clears all entries immediately.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      entry_r <= '0;
    end else begin
      entry_r <= entry_nxt_s;
    end
  end

  assign array = entry_r;

endmodule

// File: tb/tb_htf_array_inc.sv
module tb_htf_array_inc;

  localparam int DEPTH = 27;
  localparam int BASE  = 1;
  localparam int HI    = BASE + DEPTH - 1;
  localparam int W     = 10;
  localparam int NP    = 2;

  logic                          clk;
  logic                          rst_n;
  logic [HI:BASE]                preload_en;
  logic [W-1:0]                  preload_data;
  logic [NP-1:0][HI:BASE]        inc_onehot;
  logic [HI:BASE][W-1:0]         array;

  int unsigned mdl [BASE:HI];
  int n_checks;
  int n_errs;

  htf_array_inc #(
    .DEPTH(DEPTH), .RANGE_BASE(BASE), .WIDTH(W), .NUM_INC_PORTS(NP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .preload_en(preload_en),
    .preload_data(preload_data), .inc_onehot(inc_onehot), .array(array)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    for (int e = BASE; e <= HI; e++) begin
      chk($sformatf("%s[%0d]", tag, e), {22'd0, array[e]}, mdl[e]);
    end
  endtask

  // Reference behaviour of one rising edge, from the current inputs.
  task automatic model_edge();
    int unsigned n;
    for (int e = BASE; e <= HI; e++) begin
      if (rst_n) begin
        mdl[e] = 0;
      end else if (preload_en[e]) begin
        mdl[e] = preload_data;
      end else begin
        n = 0;
        for (int p = 0; p < NP; p++) if (inc_onehot[p][e]) n++;
        mdl[e] = (mdl[e] + n) % (1 << W);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    preload_en   = '0;
    preload_data = '0;
    inc_onehot   = '0;
  endtask

  task automatic preload_one(input int e, input int unsigned v);
    idle();
    preload_en[e] = 1'b1;
    preload_data  = W'(v);
    tick("pre");
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    idle();
    for (int e = BASE; e <= HI; e++) mdl[e] = 0;

    // Reset and idle release
    rst_n = 1'b1;
    #3;
    check_all("rst");
    tick("rst_hold");
    #2;
    rst_n = 1'b0;
    tick("idle");
    tick("idle2");

    // Single-entry preload
    preload_en[3] = 1'b1;
    preload_data  = 10'd17;
    tick("pre3");
    chk("pre3_val", {22'd0, array[3]}, 32'd17);
    idle();

    // Both ports on one entry
    preload_one(5, 40);
    inc_onehot[0][5] = 1'b1;
    inc_onehot[1][5] = 1'b1;
    tick("dual");
    chk("dual_val", {22'd0, array[5]}, 32'd42);
    idle();

    // Ports on different entries, including both range ends
    preload_one(27, 9);
    inc_onehot[0][1]  = 1'b1;
    inc_onehot[1][27] = 1'b1;
    tick("split");
    chk("split_lo", {22'd0, array[1]}, 32'd1);
    chk("split_hi", {22'd0, array[27]}, 32'd10);
    idle();

    // Preload priority over increment
    preload_en[4]    = 1'b1;
    preload_data     = 10'd100;
    inc_onehot[0][4] = 1'b1;
    tick("prio");
    chk("prio_val", {22'd0, array[4]}, 32'd100);
    idle();

    // Wrap with one and with two ports
    preload_one(2, 1023);
    inc_onehot[0][2] = 1'b1;
    tick("wrap1");
    chk("wrap1_val", {22'd0, array[2]}, 32'd0);
    idle();
    preload_one(2, 1022);
    inc_onehot[0][2] = 1'b1;
    inc_onehot[1][2] = 1'b1;
    tick("wrap2");
    chk("wrap2_val", {22'd0, array[2]}, 32'd0);
    idle();

    // Multi-preload in one cycle
    preload_en   = '1;
    preload_data = 10'd513;
    tick("preall");
    idle();

    // Randomized traffic with occasional mid-run resets
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      if ($urandom_range(0, 7) == 0) begin
        preload_en   = HI'($urandom & $urandom);
        preload_data = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1018, 1023)) : W'($urandom);
      end
      for (int p = 0; p < NP; p++) begin
        case ($urandom_range(0, 3))
          1, 2:    inc_onehot[p][$urandom_range(BASE, HI)] = 1'b1;
          3:       inc_onehot[p] = HI'($urandom & $urandom & $urandom);
          default: inc_onehot[p] = '0;
        endcase
      end
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_n = 1'b1;
        #1;
        for (int e = BASE; e <= HI; e++) mdl[e] = 0;
        check_all("rst_async");
        tick("rst_mid");
        #2;
        rst_n = 1'b0;
      end else begin
        tick("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
